// File: rtl/pc_pkg.sv
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared types and default constants for the program-counter
//                unit of the fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    // Source selected for the next PC value.
    typedef enum logic [2:0] {
        SEL_INC  = 3'd0,
        SEL_BR   = 3'd1,
        SEL_JMP  = 3'd2,
        SEL_CALL = 3'd3,
        SEL_RET  = 3'd4,
        SEL_TRAP = 3'd5
    } pc_sel_t;

    localparam int PC_W_DEF      = 8;
    localparam int RESET_VEC_DEF = 0;

endpackage : pc_pkg

`default_nettype wire

// File: rtl/pc_unit_ras_stack.sv
// ============================================================================
//  Module      : ras_stack
//  Description : Return-address stack built as a circular buffer with a top
//                pointer. A push while full overwrites the oldest entry and
//                leaves the count saturated at DEPTH. Reset clears only the
//                pointer and the count; entry contents are don't-care.
//  Ports       : clk, reset (async, active-high)
//                push_i / pop_i  - stack operations (push wins if both)
//                data_i          - value to push
//                data_o          - current top entry
//                count_o         - number of valid entries
//                full_o/empty_o  - count_o == DEPTH / count_o == 0
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ras_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               data_i,
    output logic [W-1:0]               data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int               PW      = $clog2(DEPTH);
    localparam logic [PW:0]      C_DEPTH = (PW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] top_q;
    logic [PW:0]   count_q;
    logic [PW-1:0] top_inc;
    logic [PW-1:0] top_dec;

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    assign top_inc = top_q + 1'b1;
    assign top_dec = top_q - 1'b1;

    assign data_o  = mem_q[top_q];
    assign count_o = count_q;
    assign full_o  = (count_q == C_DEPTH);
    assign empty_o = (count_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_q   <= '0;
            count_q <= '0;
        end else if (push_i) begin
            top_q <= top_inc;
            if (!full_o) begin
                count_q <= count_q + 1'b1;
            end
        end else if (pop_i && !empty_o) begin
            top_q   <= top_dec;
            count_q <= count_q - 1'b1;
        end
    end

    // Entry storage needs no reset; a push lands one slot above the top,
    // which is the oldest entry when the stack is full.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[top_inc] <= data_i;
        end
    end

endmodule : ras_stack

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
//  Module      : pc_unit
//  Description : Program-counter unit for the fetch stage. Selects the next
//                PC from increment, branch, jump, call or return with
//                priority stall > ret > call > jump > branch > increment, and
//                keeps return addresses in a circular return-address stack.
//                Reports stack overflow/underflow as one-cycle pulses.
//  Ports       : clk, reset (async, active-high), stall,
//                branch_en/branch_tgt, jump_en/jump_tgt, call_en/call_tgt,
//                ret_en -> pc_out (registered), pc_plus (combinational),
//                ras_count, ras_full, ras_empty, ras_ovf, ras_unf, trap
//  Config      : PC_TRAP_EN - overflowing call / underflowing ret redirect to
//                TRAP_VEC (no push on overflow) and raise trap. When
//                undefined, overflow overwrites the oldest entry, underflow
//                advances to pc_plus, and trap is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_unit
    import pc_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
    parameter int              INC       = 1,
    parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'('hF0)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         branch_en,
    input  logic [PC_W-1:0]              branch_tgt,
    input  logic                         jump_en,
    input  logic [PC_W-1:0]              jump_tgt,
    input  logic                         call_en,
    input  logic [PC_W-1:0]              call_tgt,
    input  logic                         ret_en,
    output logic [PC_W-1:0]              pc_out,
    output logic [PC_W-1:0]              pc_plus,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_full,
    output logic                         ras_empty,
    output logic                         ras_ovf,
    output logic                         ras_unf,
    output logic                         trap
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic [PC_W-1:0] ras_top;
    logic            push, pop;
    pc_sel_t         sel;

    assign pc_plus = pc_q + PC_W'(INC);

    ras_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pc_plus),
        .data_o  (ras_top),
        .count_o (ras_count),
        .full_o  (ras_full),
        .empty_o (ras_empty)
    );

    // Next-PC selection and stack control.
    always_comb begin
        sel   = SEL_INC;
        push  = 1'b0;
        pop   = 1'b0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (!stall) begin
            if (ret_en) begin
                if (ras_empty) begin
                    unf_d = 1'b1;
`ifdef PC_TRAP_EN
                    sel   = SEL_TRAP;
`else
                    sel   = SEL_INC;
`endif
                end else begin
                    sel = SEL_RET;
                    pop = 1'b1;
                end
            end else if (call_en) begin
                ovf_d = ras_full;
`ifdef PC_TRAP_EN
                if (ras_full) begin
                    sel = SEL_TRAP;
                end else begin
                    sel  = SEL_CALL;
                    push = 1'b1;
                end
`else
                sel  = SEL_CALL;
                push = 1'b1;
`endif
            end else if (jump_en) begin
                sel = SEL_JMP;
            end else if (branch_en) begin
                sel = SEL_BR;
            end
        end
    end

    always_comb begin
        pc_d = pc_plus;
        if (stall) begin
            pc_d = pc_q;
        end else begin
            case (sel)
                SEL_INC:  pc_d = pc_plus;
                SEL_BR:   pc_d = branch_tgt;
                SEL_JMP:  pc_d = jump_tgt;
                SEL_CALL: pc_d = call_tgt;
                SEL_RET:  pc_d = ras_top;
                SEL_TRAP: pc_d = TRAP_VEC;
                default:  pc_d = pc_plus;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_VEC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

`ifdef PC_TRAP_EN
    logic trap_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= ovf_d | unf_d;
        end
    end

    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    assign pc_out  = pc_q;
    assign ras_ovf = ovf_q;
    assign ras_unf = unf_q;

endmodule : pc_unit

`default_nettype wire
